// File: rtl/gpr_wb_arbiter.sv
// Two-source (ALU/LSU) GPR writeback arbiter with 1-bit round-robin and registered RF write port.
// Optional pending-write scoreboard enabled by defining GPR_WB_SCOREBOARD_EN.
module gpr_wb_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_OP_WIDTH = 5,
    parameter int REG_CNT      = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [REG_OP_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]   alu_data,
    input  logic                    lsu_valid,
    output logic                    lsu_ready,
    input  logic [REG_OP_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0]   lsu_data,
    output logic                    rf_wen,
    output logic [REG_OP_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0]   rf_wdata,
    input  logic                    iss_valid,
    input  logic [REG_OP_WIDTH-1:0] iss_rd,
    output logic [REG_CNT-1:0]      busy
);

    logic                    last_lsu_q, last_lsu_d;
    logic                    rf_wen_q, rf_wen_d;
    logic [REG_OP_WIDTH-1:0] rf_rd_q, rf_rd_d;
    logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
    logic                    alu_gnt_s, lsu_gnt_s, xfer_s;
    logic [REG_OP_WIDTH-1:0] wb_rd_s;
    logic [DATA_WIDTH-1:0]   wb_data_s;

    // Grant selection; readies are forced low while reset is asserted.
    always_comb begin
        alu_gnt_s = 1'b0;
        lsu_gnt_s = 1'b0;
        if (!reset) begin
            alu_gnt_s = 1'b0;
            lsu_gnt_s = 1'b0;
        end else begin
            case ({alu_valid, lsu_valid})
                2'b11: begin
                    alu_gnt_s = last_lsu_q;
                    lsu_gnt_s = ~last_lsu_q;
                end
                2'b10:   alu_gnt_s = 1'b1;
                2'b01:   lsu_gnt_s = 1'b1;
                default: begin
                    alu_gnt_s = 1'b0;
                    lsu_gnt_s = 1'b0;
                end
            endcase
        end
    end

    assign alu_ready = alu_gnt_s;
    assign lsu_ready = lsu_gnt_s;
    assign xfer_s    = alu_gnt_s | lsu_gnt_s;
    assign wb_rd_s   = lsu_gnt_s ? lsu_rd : alu_rd;
    assign wb_data_s = lsu_gnt_s ? lsu_data : alu_data;

    // Next-state for the round-robin pointer and the registered write port.
    always_comb begin
        last_lsu_d = last_lsu_q;
        rf_wen_d   = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (xfer_s) begin
            last_lsu_d = lsu_gnt_s;
            rf_rd_d    = wb_rd_s;
            rf_wdata_d = wb_data_s;
            rf_wen_d   = (wb_rd_s != {REG_OP_WIDTH{1'b0}});
        end else begin
            rf_wen_d   = 1'b0;
        end
    end

    // Pointer resets to "LSU last" so the ALU wins the first contended cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_lsu_q <= 1'b1;
            rf_wen_q   <= 1'b0;
            rf_rd_q    <= {REG_OP_WIDTH{1'b0}};
            rf_wdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            last_lsu_q <= last_lsu_d;
            rf_wen_q   <= rf_wen_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;

`ifdef GPR_WB_SCOREBOARD_EN
    logic [REG_CNT-1:0] busy_q, busy_d;

    // Issue set takes priority over a same-cycle writeback clear; entry 0 never tracks.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < REG_CNT; i++) begin
            busy_d[i] = (iss_valid && (iss_rd == REG_OP_WIDTH'(i))) |
                        (busy_q[i] & ~(rf_wen_d && (wb_rd_s == REG_OP_WIDTH'(i))));
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q <= {REG_CNT{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    logic unused_iss_s;

    assign unused_iss_s = iss_valid ^ (^iss_rd);
    assign busy         = {REG_CNT{1'b0}};
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed self-checking bench for gpr_wb_arbiter (scoreboard expectations follow GPR_WB_SCOREBOARD_EN).
module tb_gpr_wb_arbiter;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int RC = 32;
`ifdef GPR_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [RW-1:0] alu_rd, lsu_rd, rf_rd, iss_rd;
    logic [DW-1:0] alu_data, lsu_data, rf_wdata;
    logic          rf_wen, iss_valid;
    logic [RC-1:0] busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    gpr_wb_arbiter #(.DATA_WIDTH(DW), .REG_OP_WIDTH(RW), .REG_CNT(RC)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] sb_bit(input int n);
        logic [63:0] v;
        v = 64'd0;
        if (SB) v[n] = 1'b1;
        return v;
    endfunction

    initial begin
        reset = 1'b0; iss_valid = 1'b0; iss_rd = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h5555;
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h6666;
        #2;
        check("rst_rf_wen", rf_wen, 1'b0);
        check("rst_rf_rd", rf_rd, 5'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_alu_ready", alu_ready, 1'b0);
        check("rst_lsu_ready", lsu_ready, 1'b0);
        tick();
        check("rst_hold_rf_wen", rf_wen, 1'b0);
        reset = 1'b1;

        // Contention right after reset: ALU, LSU, ALU, LSU
        alu_rd = 5'd1; alu_data = 32'hA1; lsu_rd = 5'd2; lsu_data = 32'hB2;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("cont_alu_ready", alu_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
            check("cont_lsu_ready", lsu_ready, (i % 2 == 0) ? 1'b0 : 1'b1);
            tick();
            check("cont_rf_wen", rf_wen, 1'b1);
            check("cont_rf_rd", rf_rd, (i % 2 == 0) ? 5'd1 : 5'd2);
            check("cont_rf_wdata", rf_wdata, (i % 2 == 0) ? 32'hA1 : 32'hB2);
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
        check("idle_rf_wen", rf_wen, 1'b0);
        check("idle_rf_rd_hold", rf_rd, 5'd2);
        check("idle_rf_wdata_hold", rf_wdata, 32'hB2);

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        #1;
        check("alu_only_ready", alu_ready, 1'b1);
        check("alu_only_lsu_ready", lsu_ready, 1'b0);
        tick();
        alu_valid = 1'b0;
        check("alu_only_rf_wen", rf_wen, 1'b1);
        check("alu_only_rf_rd", rf_rd, 5'd5);
        check("alu_only_rf_wdata", rf_wdata, 32'h1234);
        check("alu_only_busy", busy, 32'd0);
        tick();
        check("alu_only_after_rf_wen", rf_wen, 1'b0);

        // Zero-register write accepted but not performed
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF_FFFF;
        #1;
        check("zero_lsu_ready", lsu_ready, 1'b1);
        tick();
        lsu_valid = 1'b0;
        check("zero_rf_wen", rf_wen, 1'b0);
        check("zero_busy", busy, 32'd0);

        // Scoreboard: issue to r0 ignored, set r7, set-wins collision, then clear
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick();
        check("sb_iss_r0", busy, 32'd0);
        iss_rd = 5'd7;
        tick();
        check("sb_set7", busy, sb_bit(7));
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        tick();
        iss_valid = 1'b0;
        check("sb_collide_busy", busy, sb_bit(7));
        check("sb_collide_rf_wen", rf_wen, 1'b1);
        tick();
        alu_valid = 1'b0;
        check("sb_clear_busy", busy, 32'd0);
        check("sb_clear_rf_wen", rf_wen, 1'b1);
        check("sb_clear_rf_rd", rf_rd, 5'd7);

        // Reset mid-operation; pointer would favour LSU without the reset
        iss_valid = 1'b1; iss_rd = 5'd3;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        tick();
        iss_valid = 1'b0; alu_valid = 1'b0;
        check("mid_pre_rf_wen", rf_wen, 1'b1);
        check("mid_pre_busy", busy, sb_bit(3));
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
        #1;
        check("mid_lsu_ready", lsu_ready, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_rf_wen", rf_wen, 1'b0);
        check("mid_rst_busy", busy, 32'd0);
        check("mid_rst_rf_rd", rf_rd, 5'd0);
        check("mid_rst_lsu_ready", lsu_ready, 1'b0);
        tick();
        check("mid_rst_discard", rf_wen, 1'b0);
        reset = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        lsu_rd = 5'd10; lsu_data = 32'hAA;
        #1;
        check("post_rst_alu_ready", alu_ready, 1'b1);
        check("post_rst_lsu_ready", lsu_ready, 1'b0);
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        check("post_rst_rf_rd", rf_rd, 5'd9);
        check("post_rst_rf_wdata", rf_wdata, 32'h99);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/gpr_wb_arbiter.md
GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning GPR data width.
REQ-002 The block SHALL have parameter REG_OP_WIDTH, default 5, meaning register index width.
REQ-003 The block SHALL have parameter REG_CNT, default 32, meaning number of GPRs and scoreboard bits.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports alu_valid/alu_ready, in/out, 1 bit each: ALU result handshake.
REQ-007 The block SHALL have ports alu_rd (in, REG_OP_WIDTH) and alu_data (in, DATA_WIDTH): ALU destination and result.
REQ-008 The block SHALL have ports lsu_valid/lsu_ready, in/out, 1 bit each: load result handshake.
REQ-009 The block SHALL have ports lsu_rd (in, REG_OP_WIDTH) and lsu_data (in, DATA_WIDTH): load destination and data.
REQ-010 The block SHALL have port rf_wen, out, 1 bit: register-file write enable.
REQ-011 The block SHALL have ports rf_rd (out, REG_OP_WIDTH) and rf_wdata (out, DATA_WIDTH): register-file write index and data.
REQ-012 The block SHALL have ports iss_valid (in, 1) and iss_rd (in, REG_OP_WIDTH): issue stage reserving a destination.
REQ-013 The block SHALL have port busy, out, REG_CNT: per-GPR pending-write scoreboard.

Function
REQ-014 A source transfer SHALL occur in a cycle where its valid and ready are both 1.
REQ-015 At most one source SHALL be granted per cycle; ready SHALL be 1 only for the granted source.
REQ-016 When exactly one source is valid, it SHALL be granted that cycle.
REQ-017 When both are valid, the source not granted most recently SHALL win (1-bit round-robin pointer updated on every transfer).
REQ-018 A transfer SHALL register rd/data into rf_rd/rf_wdata and set rf_wen=1 on the next rising edge (1-cycle latency).
REQ-019 With no transfer in a cycle, rf_wen SHALL be 0 after the next edge; rf_rd/rf_wdata SHALL hold their previous values.
REQ-020 A transfer with rd==0 SHALL be accepted but SHALL produce rf_wen=0 and SHALL NOT clear any busy bit.
REQ-021 The register file always accepts writes; the block SHALL never stall a granted source.
REQ-022 A transfer with rd=N (N!=0) SHALL clear busy[N] on the same edge that raises rf_wen.
REQ-023 iss_valid with iss_rd=N (N!=0) SHALL set busy[N] on the next edge; iss_rd==0 SHALL be ignored.
REQ-024 Issue set and writeback clear of the same N in one cycle: busy[N] SHALL end at 1 (set wins).
REQ-025 busy[0] SHALL be constant 0.
REQ-026 Writeback to N with busy[N]==0 SHALL still perform the write and leave busy[N]=0.

Reset
REQ-027 While reset is low, rf_wen, rf_rd, rf_wdata and busy SHALL be 0, asynchronously.
REQ-028 Reset SHALL set the round-robin pointer so the ALU wins the first contended cycle.
REQ-029 While reset is low, alu_ready and lsu_ready SHALL be 0; a transfer in flight at reset assertion SHALL be discarded.

Configuration
REQ-030 Macro GPR_WB_SCOREBOARD_EN defined: scoreboard per REQ-022..026 SHALL be present.
REQ-031 Macro undefined: busy SHALL be constant 0, iss_valid/iss_rd SHALL be ignored, and no scoreboard flops SHALL exist; all else unchanged.

Verification
REQ-032 ALU only: alu_valid=1, rd=5, data=0x1234 -> alu_ready=1 same cycle; next cycle rf_wen=1, rf_rd=5, rf_wdata=0x1234; following cycle rf_wen=0.
REQ-033 Contention after reset: both valid for 4 cycles (ALU rd=1, LSU rd=2) -> grants ALU, LSU, ALU, LSU; rf_rd sequence 1,2,1,2 one cycle delayed.
REQ-034 Zero write: lsu_valid=1, rd=0, data=0xFFFFFFFF -> lsu_ready=1; next cycle rf_wen=0; busy unchanged.
REQ-035 Scoreboard: issue rd=7 -> busy[7]=1; same cycle issue rd=7 and ALU writeback rd=7 -> busy[7] stays 1; later writeback rd=7 alone -> busy[7]=0 with rf_wen=1.
REQ-036 Reset mid-operation: lsu transfer rd=3 accepted, reset driven low before next edge -> rf_wen=0 and busy=0 immediately; after release, next contended cycle grants ALU.
